tx_frame_arbiter: RTL and testbench
===================================

// Module: tx_frame_arbiter
// PURPOSE
//  Frame-atomic round-robin arbiter that shares one tx_mac AXI-Stream slave port among NUM_PORTS sources.
//  Sits between the host-side stream sources and tx_mac. Its master side drives tx_mac in_slave_tx_*.
//  A grant, once given, holds until the granted source completes its frame (tlast beat accepted).
// PARAMETERS
//  NUM_PORTS        4   number of requesting sources; legal range 2..8
//  AXIS_DATA_WIDTH  32  tdata width per source and on the master side
//  AXIS_DATA_BYTES  4   tkeep width; always AXIS_DATA_WIDTH/8
//  CNT_WIDTH        16  width of each per-port frame counter (only with TX_ARB_STATS_EN)
// PORTS
//  tx_clk               in   1                          single clock for the block
//  tx_rst               in   1                          asynchronous, active-low reset
//  in_slave_tx_tdata    in   NUM_PORTS*AXIS_DATA_WIDTH  source i occupies slice [i*W +: W]
//  in_slave_tx_tkeep    in   NUM_PORTS*AXIS_DATA_BYTES  per-source byte enables
//  in_slave_tx_tvalid   in   NUM_PORTS                  per-source valid
//  in_slave_tx_tlast    in   NUM_PORTS                  per-source end of frame
//  out_slave_tx_tready  out  NUM_PORTS                  per-source ready
//  out_master_tx_tdata  out  AXIS_DATA_WIDTH            to tx_mac in_slave_tx_tdata
//  out_master_tx_tkeep  out  AXIS_DATA_BYTES            to tx_mac in_slave_tx_tkeep
//  out_master_tx_tvalid out  1                          to tx_mac in_slave_tx_tvalid
//  out_master_tx_tlast  out  1                          to tx_mac in_slave_tx_tlast
//  in_master_tx_tready  in   1                          from tx_mac out_slave_tx_tready
//  out_grant            out  NUM_PORTS                  one-hot current owner; 0 when idle
//  out_busy             out  1                          1 while in PASS
//  out_frame_count      out  NUM_PORTS*CNT_WIDTH        per-port completed frames (stats)
// BEHAVIOUR
//  Reset (tx_rst=0, async) values:
//   - state=IDLE; out_grant=0; out_busy=0.
//   - last_ptr=NUM_PORTS-1, so port 0 wins first.
//   - out_frame_count=0. All tready=0. Master tvalid/tlast=0; tdata/tkeep=0.
//  FSM IDLE:
//   - Master tvalid=0; all tready=0.
//   - If any in_slave_tx_tvalid is set: pick the first asserted index searching last_ptr+1, last_ptr+2, ...
//     modulo NUM_PORTS. Register grant=that index, then go to PASS.
//   - Arbitration latency is 1 cycle; no beat transfers in IDLE.
//  FSM PASS (master outputs combinational from the granted slice; no pipeline register):
//   - out_master_tx_tdata/tkeep/tlast = granted source's signals.
//   - out_master_tx_tvalid = tvalid[g]; out_slave_tx_tready[g] = in_master_tx_tready; other treadies = 0.
//   - Non-granted master fields are don't-care, but are driven to 0 when tvalid=0.
//   - A beat transfers when tvalid[g] & in_master_tx_tready.
//   - On a transfer with tlast[g]=1: last_ptr<=g, state<=IDLE, out_grant<=0.
//   - Result: minimum of 1 idle cycle between frames; tx_mac IPG covers it.
//  Boundaries:
//   - Granted source drops tvalid mid-frame: grant held indefinitely; no timeout, no abort.
//   - Single-beat frame (tvalid+tlast on the first PASS cycle): legal; returns to IDLE next cycle.
//   - Requests from other ports during PASS: ignored until IDLE. Sources must hold tvalid (AXIS rule).
//   - Requester withdraws tvalid in the same cycle IDLE samples it: still granted.
//     Once in PASS, a transfer waits for tvalid.
//   - in_master_tx_tready low: stall; the granted source sees tready=0 and must hold its data.
//   - Reset mid-frame: frame truncated, no tlast emitted; tx_mac is reset on the same net.
// CONFIGURATION
//  TX_ARB_STATS_EN defined:
//   - out_frame_count slice i increments by 1 on each accepted tlast beat of port i.
//   - Wraps modulo 2^CNT_WIDTH.
//  TX_ARB_STATS_EN undefined:
//   - Counters not synthesised; out_frame_count tied to 0.
//   - Arbitration and datapath are identical in both builds.
// TESTING
//  T1 Reset: tx_rst=0 mid-run -> out_grant=0, all tready=0, master tvalid=0, counters=0, same cycle.
//  T2 Single source:
//   - Port 2 sends 12 beats (A1B2C3D4..3E5F7A9B, tkeep=4'hF, tlast on beat 12), tready=1.
//   - Master sees the identical 12 beats in order; out_grant=4'b0100; IDLE one cycle after tlast.
//  T3 Round-robin: all 4 ports hold 3-beat frames after reset -> grant order 0,1,2,3,0; 1 idle cycle between frames.
//  T4 Backpressure:
//   - in_master_tx_tready toggled 1/0 each cycle during a 5-beat frame from port 1.
//   - No beat dropped or duplicated; out_slave_tx_tready[1] mirrors in_master_tx_tready.
//  T5 Source gap and 1-beat frame:
//   - Port 3 deasserts tvalid 4 cycles mid-frame -> grant held; port 0 request waits.
//   - Then port 0 sends a 1-beat frame (tkeep=4'b0011) -> passes with tlast, tkeep intact.
//  T6 Stats (TX_ARB_STATS_EN): 3 frames on port 1, 1 on port 2 -> out_frame_count slices = {0,1,3,0}.
//   - With CNT_WIDTH=2, 5 frames on port 0 -> count reads 1.

Source files
------------

// File: rtl/tx_frame_arbiter.sv
// Frame-atomic round-robin arbiter that multiplexes NUM_PORTS AXI-Stream sources onto one tx_mac slave port.
// Optional per-port completed-frame counters are built when TX_ARB_STATS_EN is defined.
module tx_frame_arbiter #(
    parameter int NUM_PORTS       = 4,
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int AXIS_DATA_BYTES = 4,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                                 tx_clk,
    input  logic                                 tx_rst,
    input  logic [NUM_PORTS*AXIS_DATA_WIDTH-1:0] in_slave_tx_tdata,
    input  logic [NUM_PORTS*AXIS_DATA_BYTES-1:0] in_slave_tx_tkeep,
    input  logic [NUM_PORTS-1:0]                 in_slave_tx_tvalid,
    input  logic [NUM_PORTS-1:0]                 in_slave_tx_tlast,
    output logic [NUM_PORTS-1:0]                 out_slave_tx_tready,
    output logic [AXIS_DATA_WIDTH-1:0]           out_master_tx_tdata,
    output logic [AXIS_DATA_BYTES-1:0]           out_master_tx_tkeep,
    output logic                                 out_master_tx_tvalid,
    output logic                                 out_master_tx_tlast,
    input  logic                                 in_master_tx_tready,
    output logic [NUM_PORTS-1:0]                 out_grant,
    output logic                                 out_busy,
    output logic [NUM_PORTS*CNT_WIDTH-1:0]       out_frame_count
);

    // state   | meaning
    // IDLE    | no owner; arbitrate among valid sources
    // PASS    | granted source streams to tx_mac until its tlast beat is accepted
    localparam int IDX_W = $clog2(NUM_PORTS);

    typedef enum logic {ST_IDLE, ST_PASS} state_t;

    state_t               state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]     gidx_q, gidx_d;
    logic [IDX_W-1:0]     last_ptr_q, last_ptr_d;

    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_found;
    logic [IDX_W:0]       cand;
    logic                 g_valid;
    logic                 g_last;
    logic                 pass_valid;
    logic                 last_xfer;

    // Search starts just after the previous owner so every port gets a turn.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = {1'b0, last_ptr_q} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_PORTS)) begin
                cand = cand - (IDX_W+1)'(NUM_PORTS);
            end
            if (!pick_found && in_slave_tx_tvalid[cand[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IDX_W-1:0];
            end
        end
    end

    assign g_valid    = in_slave_tx_tvalid[gidx_q];
    assign g_last     = in_slave_tx_tlast[gidx_q];
    assign pass_valid = (state_q == ST_PASS) && g_valid;
    assign last_xfer  = pass_valid && in_master_tx_tready && g_last;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        last_ptr_d = last_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_PASS;
                    grant_d = NUM_PORTS'(1) << pick_idx;
                    gidx_d  = pick_idx;
                end
            end
            ST_PASS: begin
                if (last_xfer) begin
                    state_d    = ST_IDLE;
                    grant_d    = '0;
                    last_ptr_d = gidx_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge tx_clk or negedge tx_rst) begin
        if (!tx_rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            last_ptr_q <= IDX_W'(NUM_PORTS-1);
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            last_ptr_q <= last_ptr_d;
        end
    end

    // Master side is a pure mux of the granted slice; zeroed whenever no beat is offered.
    assign out_master_tx_tvalid = pass_valid;
    assign out_master_tx_tdata  = pass_valid ? in_slave_tx_tdata[gidx_q*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] : '0;
    assign out_master_tx_tkeep  = pass_valid ? in_slave_tx_tkeep[gidx_q*AXIS_DATA_BYTES +: AXIS_DATA_BYTES] : '0;
    assign out_master_tx_tlast  = pass_valid && g_last;
    assign out_slave_tx_tready  = grant_q & {NUM_PORTS{in_master_tx_tready}};
    assign out_grant            = grant_q;
    assign out_busy             = (state_q == ST_PASS);

`ifdef TX_ARB_STATS_EN
    logic [NUM_PORTS*CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (last_xfer) begin
            frame_cnt_d[gidx_q*CNT_WIDTH +: CNT_WIDTH] =
                frame_cnt_q[gidx_q*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge tx_clk or negedge tx_rst) begin
        if (!tx_rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign out_frame_count = frame_cnt_q;
`else
    assign out_frame_count = '0;
`endif

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed bench for tx_frame_arbiter: per-port source queues plus an ordered scoreboard of expected master beats.
module tb_tx_frame_arbiter;
    localparam int NP = 4;
    localparam int W  = 32;
    localparam int B  = 4;
    localparam int CW = 16;

    logic              tx_clk = 1'b0;
    logic              tx_rst = 1'b1;
    logic [NP*W-1:0]   in_tdata;
    logic [NP*B-1:0]   in_tkeep;
    logic [NP-1:0]     in_tvalid;
    logic [NP-1:0]     in_tlast;
    logic [NP-1:0]     out_tready;
    logic [W-1:0]      m_tdata;
    logic [B-1:0]      m_tkeep;
    logic              m_tvalid;
    logic              m_tlast;
    logic              m_tready;
    logic [NP-1:0]     grant;
    logic              busy;
    logic [NP*CW-1:0]  fcnt;

    tx_frame_arbiter #(.NUM_PORTS(NP), .AXIS_DATA_WIDTH(W), .AXIS_DATA_BYTES(B), .CNT_WIDTH(CW)) dut (
        .tx_clk              (tx_clk),
        .tx_rst              (tx_rst),
        .in_slave_tx_tdata   (in_tdata),
        .in_slave_tx_tkeep   (in_tkeep),
        .in_slave_tx_tvalid  (in_tvalid),
        .in_slave_tx_tlast   (in_tlast),
        .out_slave_tx_tready (out_tready),
        .out_master_tx_tdata (m_tdata),
        .out_master_tx_tkeep (m_tkeep),
        .out_master_tx_tvalid(m_tvalid),
        .out_master_tx_tlast (m_tlast),
        .in_master_tx_tready (m_tready),
        .out_grant           (grant),
        .out_busy            (busy),
        .out_frame_count     (fcnt)
    );

    always #5 tx_clk = ~tx_clk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        int          hold;
        int          port;
    } beat_t;

    beat_t          pq[NP][$];
    beat_t          exp_q[$];
    int             gap[NP];
    logic [CW-1:0]  model_cnt[NP];
    int             checks = 0;
    int             errors = 0;
    logic           toggle_rdy;
    logic           chk_idle_next;
    logic           chk_busy_next;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic void push_beat(input int p, input logic [31:0] d, input logic [3:0] k,
                                      input logic l, input int hold);
        beat_t b;
        b.data = d; b.keep = k; b.last = l; b.hold = hold; b.port = p;
        pq[p].push_back(b);
        exp_q.push_back(b);
    endfunction

    function automatic void update_drive();
        for (int p = 0; p < NP; p++) begin
            logic v;
            v = (pq[p].size() != 0) && (gap[p] == 0);
            in_tvalid[p]       = v;
            in_tdata[p*W +: W] = v ? pq[p][0].data : '0;
            in_tkeep[p*B +: B] = v ? pq[p][0].keep : '0;
            in_tlast[p]        = v ? pq[p][0].last : 1'b0;
        end
    endfunction

    task automatic step();
        logic [NP-1:0] acc;
        beat_t b;
        @(negedge tx_clk);
        if (chk_idle_next) begin
            chk("idle_after_tlast_busy", busy, 1'b0);
            chk("idle_after_tlast_grant", grant, '0);
        end
        if (chk_busy_next) chk("arb_latency_busy", busy, 1'b1);
        chk_idle_next = 1'b0;
        chk_busy_next = !busy && (in_tvalid != '0);
        chk("tready_non_granted", out_tready & ~grant, '0);
        if (busy) chk("tready_mirror", out_tready & grant, m_tready ? grant : '0);
        else      chk("idle_master_tvalid", m_tvalid, 1'b0);
        if (m_tvalid && m_tready) begin
            chk("sb_nonempty", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                b = exp_q.pop_front();
                chk("beat_data", m_tdata, b.data);
                chk("beat_keep", m_tkeep, b.keep);
                chk("beat_last", m_tlast, b.last);
                chk("beat_grant", grant, NP'(1) << b.port);
                if (b.last) begin
                    model_cnt[b.port] = model_cnt[b.port] + 1'b1;
                    chk_idle_next = 1'b1;
                end
            end
        end
        acc = in_tvalid & out_tready;
        @(posedge tx_clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (acc[p]) begin
                void'(pq[p].pop_front());
                if (pq[p].size() != 0) gap[p] = pq[p][0].hold;
            end else if (gap[p] > 0) begin
                gap[p]--;
            end
        end
        if (toggle_rdy) m_tready = ~m_tready;
        update_drive();
    endtask

    task automatic check_counts(input string tag);
        for (int p = 0; p < NP; p++) begin
`ifdef TX_ARB_STATS_EN
            chk(tag, fcnt[p*CW +: CW], model_cnt[p]);
`else
            chk(tag, fcnt[p*CW +: CW], '0);
`endif
        end
    endtask

    task automatic drain(input int maxc, input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            step();
            n++;
        end
        chk({tag, "_drained"}, exp_q.size() == 0, 1'b1);
        step();
        check_counts({tag, "_frame_count"});
    endtask

    task automatic do_reset();
        tx_rst = 1'b0;
        #1;
        chk("rst_grant", grant, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tready", out_tready, '0);
        chk("rst_m_tvalid", m_tvalid, 1'b0);
        chk("rst_m_tlast", m_tlast, 1'b0);
        chk("rst_m_tdata", m_tdata, '0);
        chk("rst_m_tkeep", m_tkeep, '0);
        chk("rst_frame_count", fcnt, '0);
        for (int p = 0; p < NP; p++) begin
            pq[p].delete();
            gap[p]       = 0;
            model_cnt[p] = '0;
        end
        exp_q.delete();
        chk_idle_next = 1'b0;
        chk_busy_next = 1'b0;
        update_drive();
        @(posedge tx_clk);
        @(posedge tx_clk);
        #1;
        tx_rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_tready      = 1'b1;
        toggle_rdy    = 1'b0;
        chk_idle_next = 1'b0;
        chk_busy_next = 1'b0;
        for (int p = 0; p < NP; p++) begin
            gap[p]       = 0;
            model_cnt[p] = '0;
        end
        update_drive();
        #1;
        do_reset();

        // T2: single source, 12 beats on port 2
        push_beat(2, 32'hA1B2C3D4, 4'hF, 1'b0, 0);
        for (int k = 1; k < 11; k++) push_beat(2, $urandom, 4'hF, 1'b0, 0);
        push_beat(2, 32'h3E5F7A9B, 4'hF, 1'b1, 0);
        update_drive();
        drain(40, "t2");

        // T3: all ports request at once; expected order 0,1,2,3,0
        do_reset();
        for (int f = 0; f < 5; f++) begin
            int p;
            p = f % NP;
            for (int k = 0; k < 3; k++)
                push_beat(p, {8'h30, 8'(p), 8'(f), 8'(k)}, 4'hF, k == 2, 0);
        end
        update_drive();
        drain(60, "t3");

        // T4: tx_mac ready toggling during a 5-beat frame from port 1
        toggle_rdy = 1'b1;
        for (int k = 0; k < 5; k++) push_beat(1, 32'h4000_0000 + 32'(k), 4'hF, k == 4, 0);
        update_drive();
        drain(40, "t4");
        toggle_rdy = 1'b0;
        m_tready   = 1'b1;

        // T5: port 3 stalls 4 cycles mid-frame, port 0 waits, then a 1-beat frame
        for (int k = 0; k < 6; k++) push_beat(3, 32'h5300_0000 + 32'(k), 4'hF, k == 5, (k == 2) ? 4 : 0);
        push_beat(0, 32'h0000_BEEF, 4'b0011, 1'b1, 0);
        update_drive();
        repeat (5) step();
        chk("t5_gap_grant_held", grant, 4'b1000);
        chk("t5_gap_m_tvalid", m_tvalid, 1'b0);
        chk("t5_gap_port0_tready", out_tready[0], 1'b0);
        drain(40, "t5");

        // T1: reset asserted mid-frame
        for (int k = 0; k < 8; k++) push_beat(1, 32'h1100_0000 + 32'(k), 4'hF, k == 7, 0);
        update_drive();
        repeat (4) step();
        chk("t1_midframe_busy", busy, 1'b1);
        do_reset();
        step();
        chk("t1_after_reset_busy", busy, 1'b0);

        // T6: frame statistics
        for (int k = 0; k < 2; k++) push_beat(1, 32'h6100_0000 + 32'(k), 4'hF, k == 1, 0);
        push_beat(2, 32'h6200_0000, 4'hF, 1'b1, 0);
        for (int f = 1; f < 3; f++)
            for (int k = 0; k < 2; k++)
                push_beat(1, 32'h6100_0000 + 32'(f*16 + k), 4'hF, k == 1, 0);
        update_drive();
        drain(60, "t6");
`ifdef TX_ARB_STATS_EN
        chk("t6_count_slices", fcnt, {16'd0, 16'd1, 16'd3, 16'd0});
`else
        chk("t6_count_slices", fcnt, '0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
